// File: rtl/risc16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// risc16_mem_arbiter
//
// Shares one word-wide, single-port SRAM between the risc16p instruction-fetch
// port and its data port. Each access is a fixed IDLE -> ACCESS -> DONE -> IDLE
// sequence. ACCESS lasts MEM_LAT cycles and DONE carries the one-cycle ack.
// Data requests win ties. A burst counter forces a fetch grant once
// MAX_D_BURST data grants have been made back-to-back while a fetch was waiting.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   i_req/i_addr         fetch request and byte address (held until i_ack)
//   i_rdata/i_ack        fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr    data request, store flag and byte address
//   d_wdata              store word
//   d_rdata/d_ack        loaded word and one-cycle completion pulse
//   mem_addr/mem_wdata   SRAM word address (bit 0 cleared) and write data
//   mem_oe/mem_we        SRAM read / write enables
//   mem_rdata            SRAM read data, sampled at the end of the last ACCESS cycle
//   busy                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module risc16_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LAT     = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [2:0] LAT_LAST  = 3'(MEM_LAT - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    state_e              state_q,    state_d;
    logic [2:0]          lat_cnt_q,  lat_cnt_d;
    logic [3:0]          burst_q,    burst_d;
    logic                gnt_data_q, gnt_data_d;   // 1 = current access belongs to the data port
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_oe_q,   mem_oe_d;
    logic                mem_we_q,   mem_we_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic                i_ack_q,    i_ack_d;
    logic                d_ack_q,    d_ack_d;
    logic                busy_q,     busy_d;
    logic                data_wins;

    // Data port wins unless a waiting fetch has already been passed over MAX_D_BURST times.
    always_comb begin
        if (d_req && !(i_req && (burst_q == BURST_MAX))) begin
            data_wins = 1'b1;
        end else begin
            data_wins = 1'b0;
        end
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        burst_d     = burst_q;
        gnt_data_d  = gnt_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_oe_d    = mem_oe_q;
        mem_we_d    = 1'b0;
        rdata_d     = rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d   = ST_ACCESS;
                    lat_cnt_d = 3'd0;
                    if (data_wins) begin
                        gnt_data_d  = 1'b1;
                        mem_addr_d  = {d_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_d = d_wdata;
                        mem_oe_d    = ~d_we;
                        mem_we_d    = d_we;
                        // Count only grants that made a fetch wait.
                        if (!i_req) begin
                            burst_d = 4'd0;
                        end else if (burst_q != BURST_MAX) begin
                            burst_d = burst_q + 4'd1;
                        end else begin
                            burst_d = burst_q;
                        end
                    end else begin
                        gnt_data_d  = 1'b0;
                        mem_addr_d  = {i_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_d = '0;
                        mem_oe_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        burst_d     = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // mem_we was raised for the first window cycle only; it stays 0 here.
                if (lat_cnt_q == LAT_LAST) begin
                    state_d     = ST_DONE;
                    rdata_d     = mem_rdata;
                    mem_oe_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    i_ack_d     = ~gnt_data_q;
                    d_ack_d     = gnt_data_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= 3'd0;
            burst_q     <= 4'd0;
            gnt_data_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_q     <= burst_d;
            gnt_data_q  <= gnt_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    // Both read-data ports show the single sampled word; only the acked one is meaningful.
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_risc16_mem_arbiter
//
// Directed bench for risc16_mem_arbiter. Two instances share the request
// inputs: u_dut1 (MEM_LAT=1, MAX_D_BURST=4) and u_dut3 (MEM_LAT=3). Each has
// its own small SRAM model with a combinational read and a posedge write.
// Inputs are driven 1 time unit after posedge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_risc16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;

    logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_ack1, d_ack1, mem_oe1, mem_we1, busy1;
    logic [15:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        i_ack3, d_ack3, mem_oe3, mem_we3, busy3;

    logic [15:0] sram1 [0:32767];
    logic [15:0] sram3 [0:32767];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    risc16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_D_BURST(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_oe(mem_oe1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    risc16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .MAX_D_BURST(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_ack(d_ack3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_oe(mem_oe3), .mem_we(mem_we3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // SRAM models: combinational read of the presented word address.
    always_comb begin
        mem_rdata1 = sram1[mem_addr1[15:1]];
        mem_rdata3 = sram3[mem_addr3[15:1]];
    end

    // SRAM models: write on posedge while mem_we is high.
    always @(posedge clk) begin
        if (mem_we1) sram1[mem_addr1[15:1]] <= mem_wdata1;
        if (mem_we3) sram3[mem_addr3[15:1]] <= mem_wdata3;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int          d_at, i_at, both, we_cnt, nacks, last_i, gap, acks3;
    logic [9:0]  seq;
    logic [15:0] d_data, i_data;

    initial begin
        #1;
        sram1[16'h0012 >> 1] = 16'hA5C3;
        sram1[16'h0200 >> 1] = 16'hBEEF;
        sram1[16'h0044 >> 1] = 16'h5678;
        sram1[16'hFFFE >> 1] = 16'h0F0F;
        sram3[16'h0030 >> 1] = 16'hC0DE;

        // Reset state
        do_reset();
        check_val("rst_i_ack",    {31'd0, i_ack1},  32'd0);
        check_val("rst_d_ack",    {31'd0, d_ack1},  32'd0);
        check_val("rst_mem_oe",   {31'd0, mem_oe1}, 32'd0);
        check_val("rst_mem_we",   {31'd0, mem_we1}, 32'd0);
        check_val("rst_busy",     {31'd0, busy1},   32'd0);
        check_val("rst_mem_addr", {16'd0, mem_addr1}, 32'h0000);

        // 1: single fetch from odd address
        i_req = 1'b1; i_addr = 16'h0013;
        tick();
        check_val("t1_mem_addr", {16'd0, mem_addr1}, 32'h0012);
        check_val("t1_mem_oe",   {31'd0, mem_oe1},   32'd1);
        check_val("t1_busy",     {31'd0, busy1},     32'd1);
        check_val("t1_no_ack",   {31'd0, i_ack1},    32'd0);
        tick();
        check_val("t1_i_ack",    {31'd0, i_ack1},    32'd1);
        check_val("t1_i_rdata",  {16'd0, i_rdata1},  32'hA5C3);
        check_val("t1_oe_done",  {31'd0, mem_oe1},   32'd0);
        i_req = 1'b0;
        tick();
        check_val("t1_ack_gone", {31'd0, i_ack1},    32'd0);
        check_val("t1_idle",     {31'd0, busy1},     32'd0);

        // Top-of-memory load: 0xFFFF maps to word 0xFFFE
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFF;
        tick();
        check_val("top_mem_addr", {16'd0, mem_addr1}, 32'hFFFE);
        tick();
        check_val("top_d_ack",    {31'd0, d_ack1},    32'd1);
        check_val("top_d_rdata",  {16'd0, d_rdata1},  32'h0F0F);
        d_req = 1'b0;
        tick();

        // 2: simultaneous fetch and load, data first
        do_reset();
        i_req = 1'b1; i_addr = 16'h0044;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        d_at = 99; i_at = 99; both = 0; d_data = 16'h0; i_data = 16'h0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (i_ack1 && d_ack1) both++;
            if (d_ack1 && d_at == 99) begin d_at = t; d_data = d_rdata1; d_req = 1'b0; end
            if (i_ack1 && i_at == 99) begin i_at = t; i_data = i_rdata1; i_req = 1'b0; end
        end
        check_val("t2_d_ack_cyc", d_at,   32'd2);
        check_val("t2_i_ack_cyc", i_at,   32'd5);
        check_val("t2_both_acks", both,   32'd0);
        check_val("t2_d_rdata",   {16'd0, d_data}, 32'hBEEF);
        check_val("t2_i_rdata",   {16'd0, i_data}, 32'h5678);

        // 3: store then fetch the same word
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        d_at = 99; we_cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (mem_we1) we_cnt++;
            if (d_ack1 && d_at == 99) begin d_at = t; d_req = 1'b0; d_we = 1'b0; end
        end
        check_val("t3_store_ack", d_at,   32'd2);
        check_val("t3_we_cycles", we_cnt, 32'd1);
        i_req = 1'b1; i_addr = 16'h0020;
        i_at = 99; i_data = 16'h0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (i_ack1 && i_at == 99) begin i_at = t; i_data = i_rdata1; i_req = 1'b0; end
        end
        check_val("t3_fetch_ack", i_at,  32'd2);
        check_val("t3_fetch_val", {16'd0, i_data}, 32'h1234);

        // 4: starvation guard, both requests held high
        do_reset();
        i_req = 1'b1; i_addr = 16'h0012;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        nacks = 0; seq = 10'b0; last_i = -1; gap = 0; both = 0;
        for (int t = 1; t <= 100; t++) begin
            if (nacks < 10) begin
                tick();
                if (i_ack1 && d_ack1) both++;
                if (d_ack1) begin seq = {seq[8:0], 1'b1}; nacks++; end
                if (i_ack1) begin
                    seq = {seq[8:0], 1'b0}; nacks++;
                    if (last_i >= 0 && gap == 0) gap = t - last_i;
                    last_i = t;
                end
            end
        end
        check_val("t4_ack_count", nacks, 32'd10);
        check_val("t4_grant_seq", {22'd0, seq}, {22'd0, 10'b1111011110});
        check_val("t4_fetch_gap", gap,   32'd15);
        check_val("t4_both_acks", both,  32'd0);

        // 5: reset during a store access (MEM_LAT=3)
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h7777;
        tick();
        check_val("t5_we_first",  {31'd0, mem_we3}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_val("t5_we_after_rst",   {31'd0, mem_we3}, 32'd0);
        check_val("t5_busy_after_rst", {31'd0, busy3},   32'd0);
        check_val("t5_no_dack",        {31'd0, d_ack3},  32'd0);
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        acks3 = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (d_ack3 || i_ack3) acks3++;
        end
        check_val("t5_abandoned_acks", acks3, 32'd0);
        i_req = 1'b1; i_addr = 16'h0031;
        i_at = 99; i_data = 16'h0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (i_ack3 && i_at == 99) begin i_at = t; i_data = i_rdata3; i_req = 1'b0; end
        end
        check_val("t5_post_rst_lat", i_at, 32'd4);
        check_val("t5_post_rst_val", {16'd0, i_data}, 32'hC0DE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
